ps2_event_ctrl: RTL and testbench

//  Sequencer between the PS/2 byte receiver and consumers (display, key logic). Parses raw bytes into key events
//  by tracking E0/F0/E1 prefix state, buffers events in a FIFO with valid/ready output, and keeps a 4-byte raw history
//  for the 8-digit hex display. Drops keyboard housekeeping bytes and aborts partial sequences on error or timeout.

---
 rtl/ps2_event_ctrl_if.sv | 20 ++
 rtl/ps2_event_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ps2_event_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_event_ctrl_if.sv
// Byte-receiver input and key-event output of the PS/2 event sequencer.
// The slave side is the sequencer; the master side is the receiver/consumer pair.
interface ps2_event_ctrl_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_error;
  logic [9:0] evt_data;
  logic       evt_valid;
  logic       evt_ready;

  modport master (
    output rx_byte, rx_valid, rx_error, evt_ready,
    input  evt_data, evt_valid
  );

  modport slave (
    input  rx_byte, rx_valid, rx_error, evt_ready,
    output evt_data, evt_valid
  );
endinterface

// File: rtl/ps2_event_ctrl.sv
// Parses PS/2 scan bytes (E0/F0/E1 prefixes) into {ext,brk,code} events held in a FWFT FIFO.
// Event visible one cycle after its final byte; a push into a full FIFO with no pop is dropped.
module ps2_event_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 250000
) (
  input  logic              clock,
  input  logic              reset_n,
  ps2_event_ctrl_if.slave   bus,
  output logic [31:0]       raw_hist,
  input  logic              clr_flags,
  output logic              err_flag,
  output logic              ovf_flag
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_PAUSE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      pause_cnt, pause_cnt_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic            push_vld, timeout, kbd_ovr;
  logic [9:0]      push_dat;
  logic [1:0]      rst_sync;
  logic            rst_n;

  logic [9:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, pop, wr_en, drop;

  // Reset asserts asynchronously but releases two clocks after reset_n rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pause_cnt <= '0;
      timer     <= '0;
    end else begin
      state     <= state_nxt;
      pause_cnt <= pause_cnt_nxt;
      timer     <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pause_cnt_nxt = pause_cnt;
    timer_nxt     = timer;
    push_vld      = 1'b0;
    push_dat      = '0;
    timeout       = 1'b0;
    kbd_ovr       = 1'b0;
    if (bus.rx_error) begin
      state_nxt = S_IDLE;
      timer_nxt = '0;
    end else if (bus.rx_valid) begin
      timer_nxt = '0;
      unique case (state)
        S_IDLE: begin
          case (bus.rx_byte)
            8'hE0: state_nxt = S_EXT;
            8'hF0: state_nxt = S_BRK;
            8'hE1: begin
              state_nxt     = S_PAUSE;
              pause_cnt_nxt = 3'd7;
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
            8'h00, 8'hFF: kbd_ovr = 1'b1;
            default: begin
              push_vld = 1'b1;
              push_dat = {2'b00, bus.rx_byte};
            end
          endcase
        end
        S_EXT: begin
          if (bus.rx_byte == 8'hF0) begin
            state_nxt = S_EXTBRK;
          end else if (bus.rx_byte != 8'hE0) begin
            push_vld  = 1'b1;
            push_dat  = {2'b10, bus.rx_byte};
            state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          push_vld  = 1'b1;
          push_dat  = {2'b01, bus.rx_byte};
          state_nxt = S_IDLE;
        end
        S_EXTBRK: begin
          push_vld  = 1'b1;
          push_dat  = {2'b11, bus.rx_byte};
          state_nxt = S_IDLE;
        end
        S_PAUSE: begin
          // Pause/Break is a fixed 8-byte burst reported as one extended E1 make.
          pause_cnt_nxt = pause_cnt - 3'd1;
          if (pause_cnt == 3'd1) begin
            push_vld  = 1'b1;
            push_dat  = {2'b10, 8'hE1};
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE) begin
      if (timer == TW'(TIMEOUT_CYC - 1)) begin
        timeout   = 1'b1;
        state_nxt = S_IDLE;
        timer_nxt = '0;
      end else begin
        timer_nxt = timer + 1'b1;
      end
    end else begin
      timer_nxt = '0;
    end
  end

  assign full          = (count == CW'(FIFO_DEPTH));
  assign bus.evt_valid = (count != '0);
  assign pop           = bus.evt_valid & bus.evt_ready;
  assign wr_en         = push_vld & (~full | pop);
  assign drop          = push_vld & full & ~pop;
  assign bus.evt_data  = bus.evt_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
    end
  end

  // A set condition in the same cycle as clr_flags keeps the flag high.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      raw_hist <= '0;
      err_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (bus.rx_valid) raw_hist <= {raw_hist[23:0], bus.rx_byte};
      err_flag <= bus.rx_error | timeout | (err_flag & ~clr_flags);
      ovf_flag <= drop | kbd_ovr | (ovf_flag & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_ps2_event_ctrl.sv
// Bench for ps2_event_ctrl: directed scenarios plus random byte streams against a queue-based parser model.
module tb_ps2_event_ctrl;
  localparam int DEPTH = 8;
  localparam int TOUT  = 40;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr_flags = 1'b0;
  logic [31:0] raw_hist;
  logic        err_flag, ovf_flag;

  ps2_event_ctrl_if bus();

  ps2_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)) u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .raw_hist  (raw_hist),
    .clr_flags (clr_flags),
    .err_flag  (err_flag),
    .ovf_flag  (ovf_flag)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bytes of the unfinished sequence, expected FIFO contents, flags.
  logic [9:0]  mq[$];
  logic [7:0]  pend[$];
  logic [9:0]  dut_log[$];
  int          gap;
  logic [31:0] m_hist;
  bit          m_err, m_ovf;

  task automatic model_step();
    bit pop, push, err_set, ovf_set;
    logic [9:0] ev;
    logic [7:0] b;
    pop = (mq.size() != 0) && bus.evt_ready;
    push = 0; err_set = 0; ovf_set = 0; ev = '0;
    b = bus.rx_byte;
    if (bus.rx_valid) m_hist = {m_hist[23:0], b};
    if (bus.rx_error) begin
      pend.delete(); gap = 0; err_set = 1;
    end else if (bus.rx_valid) begin
      gap = 0;
      if (pend.size() == 0) begin
        if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) pend.push_back(b);
        else if (b == 8'h00 || b == 8'hFF) ovf_set = 1;
        else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE})) begin push = 1; ev = {2'b00, b}; end
      end else if (pend[0] == 8'hE1) begin
        pend.push_back(b);
        if (pend.size() == 8) begin push = 1; ev = 10'h2E1; pend.delete(); end
      end else if (pend[pend.size()-1] == 8'hF0) begin
        push = 1; ev = {pend[0] == 8'hE0, 1'b1, b}; pend.delete();
      end else if (b == 8'hE0 || b == 8'hF0) begin
        pend.push_back(b);
      end else begin
        push = 1; ev = {2'b10, b}; pend.delete();
      end
    end else if (pend.size() != 0) begin
      gap++;
      if (gap >= TOUT) begin pend.delete(); gap = 0; err_set = 1; end
    end
    if (push && mq.size() == DEPTH && !pop) begin ovf_set = 1; push = 0; end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(ev);
    m_err = err_set | (m_err & !clr_flags);
    m_ovf = ovf_set | (m_ovf & !clr_flags);
  endtask

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      mq.delete(); pend.delete(); gap = 0; m_hist = '0; m_err = 0; m_ovf = 0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge clock);
    if (reset_n) begin
      chk("evt_valid", {31'd0, bus.evt_valid}, {31'd0, mq.size() != 0});
      chk("evt_data", {22'd0, bus.evt_data}, (mq.size() != 0) ? {22'd0, mq[0]} : 32'd0);
      chk("raw_hist", raw_hist, m_hist);
      chk("err_flag", {31'd0, err_flag}, {31'd0, m_err});
      chk("ovf_flag", {31'd0, ovf_flag}, {31'd0, m_ovf});
      if (bus.evt_valid && bus.evt_ready) dut_log.push_back(bus.evt_data);
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b);
    bus.rx_byte = b; bus.rx_valid = 1'b1;
    @(posedge clock); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic pulse_err();
    bus.rx_error = 1'b1;
    @(posedge clock); #1;
    bus.rx_error = 1'b0;
  endtask

  task automatic clear();
    clr_flags = 1'b1;
    @(posedge clock); #1;
    clr_flags = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] tbl [9];
    int k;
    tbl = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    k = $urandom_range(0, 15);
    if (k < 9) return tbl[k];
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pause_seq [10];
    bus.rx_byte = '0; bus.rx_valid = 1'b0; bus.rx_error = 1'b0; bus.evt_ready = 1'b0;
    #3;
    chk("rst_evt_valid", {31'd0, bus.evt_valid}, 32'd0);
    chk("rst_evt_data", {22'd0, bus.evt_data}, 32'd0);
    chk("rst_raw_hist", raw_hist, 32'd0);
    chk("rst_flags", {30'd0, err_flag, ovf_flag}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(4);

    // Make then break of 1C, consumer always ready.
    bus.evt_ready = 1'b1;
    dut_log.delete();
    send(8'h1C);
    chk("lat_make", {31'd0, bus.evt_valid}, 32'd1);
    send(8'hF0);
    chk("lat_prefix", {31'd0, bus.evt_valid}, 32'd0);
    send(8'h1C);
    chk("lat_break", {31'd0, bus.evt_valid}, 32'd1);
    chk("hist_1c", raw_hist, 32'h001CF01C);
    idle(2);
    chk("t1_cnt", dut_log.size(), 2);
    chk("t1_ev0", {22'd0, dut_log[0]}, 32'h01C);
    chk("t1_ev1", {22'd0, dut_log[1]}, 32'h11C);

    // Extended make / break.
    dut_log.delete();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    idle(2);
    chk("t2_cnt", dut_log.size(), 2);
    chk("t2_ev0", {22'd0, dut_log[0]}, 32'h275);
    chk("t2_ev1", {22'd0, dut_log[1]}, 32'h375);

    // Pause sequence surrounded by housekeeping bytes.
    dut_log.delete();
    pause_seq = '{8'hAA, 8'hFA, 8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    foreach (pause_seq[i]) send(pause_seq[i]);
    send(8'hEE); send(8'hFE);
    idle(2);
    chk("t3_cnt", dut_log.size(), 1);
    chk("t3_ev", {22'd0, dut_log[0]}, 32'h2E1);

    // Overflow: nine makes into an eight-deep FIFO.
    clear();
    bus.evt_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send(8'(i));
    chk("t4_ovf", {31'd0, ovf_flag}, 32'd1);
    dut_log.delete();
    bus.evt_ready = 1'b1;
    idle(10);
    chk("t4_cnt", dut_log.size(), 8);
    for (int i = 0; i < 8; i++) chk("t4_order", {22'd0, dut_log[i]}, i + 1);

    // Full FIFO with simultaneous push and pop: no drop.
    clear();
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i));
    dut_log.delete();
    bus.evt_ready = 1'b1;
    send(8'h19);
    chk("t5_no_ovf", {31'd0, ovf_flag}, 32'd0);
    idle(12);
    chk("t5_cnt", dut_log.size(), 9);
    chk("t5_last", {22'd0, dut_log[8]}, 32'h019);

    // Timeout boundary: one cycle short survives, full gap aborts.
    clear();
    dut_log.delete();
    send(8'hE0); idle(TOUT - 1); send(8'h75);
    idle(2);
    chk("t6_no_err", {31'd0, err_flag}, 32'd0);
    send(8'hE0); idle(TOUT);
    chk("t6_err", {31'd0, err_flag}, 32'd1);
    send(8'h75);
    idle(2);
    chk("t6_cnt", dut_log.size(), 2);
    chk("t6_ev0", {22'd0, dut_log[0]}, 32'h275);
    chk("t6_ev1", {22'd0, dut_log[1]}, 32'h075);

    // rx_error after F0 aborts the break.
    clear();
    dut_log.delete();
    send(8'hF0); pulse_err(); idle(2);
    chk("t7_err", {31'd0, err_flag}, 32'd1);
    send(8'h1C); idle(2);
    chk("t7_cnt", dut_log.size(), 1);
    chk("t7_ev", {22'd0, dut_log[0]}, 32'h01C);

    // Reset with events queued and a sequence half-parsed.
    bus.evt_ready = 1'b0;
    send(8'h1C); send(8'h2C); send(8'h3C); send(8'hE0);
    #2 reset_n = 1'b0;
    #1;
    chk("t8_evt_valid", {31'd0, bus.evt_valid}, 32'd0);
    chk("t8_raw_hist", raw_hist, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(4);
    dut_log.delete();
    bus.evt_ready = 1'b1;
    send(8'h1C); idle(2);
    chk("t8_cnt", dut_log.size(), 1);
    chk("t8_ev", {22'd0, dut_log[0]}, 32'h01C);

    // Random streams; the per-cycle checker compares against the model.
    for (int i = 0; i < 1500; i++) begin
      int r;
      bit stall;
      stall = ((i / 200) % 2) == 1;
      bus.evt_ready = stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      if (r < 3) pulse_err();
      else if (r < 5) idle(TOUT + 2);
      else if (r < 9) begin
        clr_flags = 1'b1;
        send(rand_byte());
        clr_flags = 1'b0;
      end else send(rand_byte());
      idle($urandom_range(0, 2));
    end
    bus.evt_ready = 1'b1;
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
